ccd_pattern_gen: RTL and testbench
==================================

// Module: ccd_pattern_gen
// PURPOSE
// - Synthetic CCD pixel-stream source; drives the same R/G/B + X/Y + new_frame/end_frame interface the red-point detector consumes.
// - Raster-scans a programmable frame with blanking and paints one red square target at a programmable position on a non-red background.
// - Replaces the camera in bring-up and regression, giving the detector a known target position per frame.
// PARAMETERS
// - H_ACTIVE  640  active pixels per line
// - V_ACTIVE  480  active lines per frame
// - H_BLANK   16   idle cycles between lines; not inserted after the last line
// - V_BLANK   4    idle cycles after the last line, before the next frame start
// - DATA_W    10   bits per colour channel
// - POS_W     13   bits per X/Y coordinate
// PORTS
// - clk          in   1       clock
// - rst          in   1       reset, synchronous, active-low
// - i_enable     in   1       run frames while high
// - i_mode       in   1       0: flat grey background; 1: green gradient background (G = X[DATA_W-1:0])
// - i_tgt_x      in   POS_W   target left column
// - i_tgt_y      in   POS_W   target top row
// - i_tgt_size   in   POS_W   target edge length in pixels; 0 = no target
// - o_R/o_G/o_B  out  DATA_W  pixel colour
// - o_X_pos      out  POS_W   column of current pixel
// - o_Y_pos      out  POS_W   row of current pixel
// - o_valid      out  1       high on active-pixel cycles
// - o_new_frame  out  1       1-cycle pulse, frame start
// - o_end_frame  out  1       1-cycle pulse, frame end
// - o_frame_cnt  out  16      completed-frame counter, wraps at 2^16
// BEHAVIOUR
// - All outputs registered. Reset (rst==0): state IDLE, every output 0.
// - FSM states: IDLE, FSTART, ACTIVE, HBLANK, VBLANK.
// - IDLE: outputs 0. Moves to FSTART when i_enable==1.
// - FSTART: exactly 1 cycle. o_new_frame=1, X=Y=0, o_valid=0. Latches i_mode, i_tgt_x/y/size; they stay fixed for the whole frame.
// - ACTIVE: o_valid=1. X counts 0..H_ACTIVE-1. At X==H_ACTIVE-1:
//   - if Y<V_ACTIVE-1: go to HBLANK.
//   - else: go to VBLANK.
// - HBLANK: H_BLANK cycles, o_valid=0, X/Y hold. Then ACTIVE with X=0, Y+1.
// - VBLANK: V_BLANK cycles, o_valid=0, X/Y hold at last pixel.
//   - First VBLANK cycle: o_end_frame=1 and o_frame_cnt increments.
//   - On exit: FSTART if i_enable==1, else IDLE.
// - Frame period = 1 + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK cycles.
// - Pixel colour, ACTIVE only:
//   - Target pixel: tx<=X<tx+size and ty<=Y<ty+size. Compare at POS_W+1 bits (no wrap); the square clips at frame edges.
//   - Target pixel colour: R=all-ones, G=0, B=0.
//   - Background, mode 0: R=G=B=10'h100.
//   - Background, mode 1: R=B=10'h100, G=X[DATA_W-1:0].
// - Non-ACTIVE cycles: R=G=B=0.
// - Invariant: background never satisfies the detector red test (R[9:5]>16, G[9:5]<6, B[9:5]<6).
// - i_enable dropped mid-frame: the current frame completes, including VBLANK, then IDLE.
// - Target registers changing mid-frame have no effect until the next FSTART.
// - Reset mid-frame: immediate return to IDLE; no o_end_frame is emitted.
// STRUCTURE
// - Shared package pixel_pkg:
//   - DATA_W/POS_W defaults.
//   - RED/GREEN/BLUE threshold constants (16, 6, 6 on bits [9:5]), shared with the detector.
//   - RED_PIXEL and GREY_BG constants.
//   - FSM state enum.
// - Sub-module raster_timing: owns the FSM and the X/Y/blank counters; emits valid/new_frame/end_frame/X/Y.
// - Top level: config latch, target compare, colour mux, output registers.
// TESTING (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=3; frame = 42 cycles)
// - Reset held, then released with i_enable=1 -> o_new_frame 1 cycle later; next o_new_frame exactly 42 cycles after it; o_valid high 32 cycles per frame.
// - tgt=(3,1), size=2 -> red exactly at (3,1),(4,1),(3,2),(4,2); detector fed this stream pulses detect once, reporting X=3, Y=1.
// - tgt=(7,3), size=4 -> only (7,3) red (edge clip); tgt size=0 -> no red pixel in either background mode.
// - i_enable dropped at (5,2) -> frame finishes, o_end_frame pulses, o_frame_cnt +1, then IDLE with all outputs 0.
// - rst asserted at (2,1) -> next cycle all outputs 0, no o_end_frame; with i_enable high, a fresh frame starts at X=Y=0.
// - i_tgt_x changed mid-frame -> red position changes only from the following frame.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel-stream definitions: default widths, detector red-test thresholds,
// reference colours and the raster FSM state encoding.
package pixel_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_POS_W  = 13;

  localparam logic [4:0] RED_THR   = 5'd16;
  localparam logic [4:0] GREEN_THR = 5'd6;
  localparam logic [4:0] BLUE_THR  = 5'd6;

  localparam logic [DEF_DATA_W-1:0] RED_PIXEL = '1;
  localparam logic [DEF_DATA_W-1:0] GREY_BG   = 10'h100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FSTART,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  // Same red test the detector applies; grey and green-gradient backgrounds never pass it.
  function automatic logic is_red(input logic [DEF_DATA_W-1:0] r,
                                  input logic [DEF_DATA_W-1:0] g,
                                  input logic [DEF_DATA_W-1:0] b);
    return (r[9:5] > RED_THR) && (g[9:5] < GREEN_THR) && (b[9:5] < BLUE_THR);
  endfunction

endpackage

// File: rtl/raster_timing.sv
// Raster FSM: walks FSTART, active lines with horizontal blanking, and the
// closing vertical blanking; emits registered X/Y, valid and frame pulses.
module raster_timing
  import pixel_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int POS_W    = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  output logic [POS_W-1:0] x_p0,
  output logic [POS_W-1:0] y_p0,
  output logic             vld_p0,
  output logic             nf_p0,
  output logic             ef_p0,
  output logic [15:0]      frame_cnt_p0
);

  localparam int CNT_W = 16;
  localparam logic [POS_W-1:0] X_LAST  = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_LAST  = POS_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);

  state_t           state;
  logic [CNT_W-1:0] blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      x_p0         <= '0;
      y_p0         <= '0;
      vld_p0       <= 1'b0;
      nf_p0        <= 1'b0;
      ef_p0        <= 1'b0;
      frame_cnt_p0 <= '0;
      blk_cnt      <= '0;
    end else begin
      nf_p0 <= 1'b0;
      ef_p0 <= 1'b0;
      case (state)
        ST_IDLE: begin
          vld_p0 <= 1'b0;
          x_p0   <= '0;
          y_p0   <= '0;
          if (i_enable) begin
            state <= ST_FSTART;
            nf_p0 <= 1'b1;
          end
        end
        ST_FSTART: begin
          state  <= ST_ACTIVE;
          vld_p0 <= 1'b1;
          x_p0   <= '0;
          y_p0   <= '0;
        end
        ST_ACTIVE: begin
          if (x_p0 == X_LAST) begin
            vld_p0  <= 1'b0;
            blk_cnt <= '0;
            if (y_p0 < Y_LAST) begin
              state <= ST_HBLANK;
            end else begin
              state        <= ST_VBLANK;
              ef_p0        <= 1'b1;
              frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
            end
          end else begin
            x_p0 <= x_p0 + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (blk_cnt == HB_LAST) begin
            state  <= ST_ACTIVE;
            vld_p0 <= 1'b1;
            x_p0   <= '0;
            y_p0   <= y_p0 + 1'b1;
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          // X/Y hold at the last pixel until the frame is closed out.
          if (blk_cnt == VB_LAST) begin
            x_p0 <= '0;
            y_p0 <= '0;
            if (i_enable) begin
              state <= ST_FSTART;
              nf_p0 <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ccd_pattern_gen.sv
// Synthetic CCD source: raster timing plus a per-frame latched red square target
// painted over a grey or green-gradient background.
module ccd_pattern_gen
  import pixel_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int POS_W    = DEF_POS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic [POS_W-1:0]  i_tgt_x,
  input  logic [POS_W-1:0]  i_tgt_y,
  input  logic [POS_W-1:0]  i_tgt_size,
  output logic [DATA_W-1:0] o_R,
  output logic [DATA_W-1:0] o_G,
  output logic [DATA_W-1:0] o_B,
  output logic [POS_W-1:0]  o_X_pos,
  output logic [POS_W-1:0]  o_Y_pos,
  output logic              o_valid,
  output logic              o_new_frame,
  output logic              o_end_frame,
  output logic [15:0]       o_frame_cnt
);

  logic [POS_W-1:0] x_p0, y_p0;
  logic             vld_p0, nf_p0, ef_p0;
  logic [15:0]      frame_cnt_p0;

  raster_timing #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .H_BLANK (H_BLANK),  .V_BLANK (V_BLANK),
    .POS_W   (POS_W)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .x_p0         (x_p0),
    .y_p0         (y_p0),
    .vld_p0       (vld_p0),
    .nf_p0        (nf_p0),
    .ef_p0        (ef_p0),
    .frame_cnt_p0 (frame_cnt_p0)
  );

  logic             mode_q;
  logic [POS_W-1:0] tx_q, ty_q, sz_q;

  always_ff @(posedge clk) begin
    if (nf_p0) begin
      mode_q <= i_mode;
      tx_q   <= i_tgt_x;
      ty_q   <= i_tgt_y;
      sz_q   <= i_tgt_size;
    end
  end

  function automatic logic [3*DATA_W-1:0] pixel_colour(input logic              tgt,
                                                       input logic              mode,
                                                       input logic [DATA_W-1:0] gx);
    logic [DATA_W-1:0] grey;
    grey = DATA_W'(GREY_BG);
    if (tgt)       return {{DATA_W{1'b1}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}};
    else if (mode) return {grey, gx, grey};
    else           return {grey, grey, grey};
  endfunction

  // One extra bit so tgt+size never wraps; the square simply clips at the frame edge.
  logic [POS_W:0]        x_e, y_e, tx_end, ty_end;
  logic                  in_tgt;
  logic [3*DATA_W-1:0]   rgb_p0;

  always_comb begin
    x_e    = {1'b0, x_p0};
    y_e    = {1'b0, y_p0};
    tx_end = {1'b0, tx_q} + {1'b0, sz_q};
    ty_end = {1'b0, ty_q} + {1'b0, sz_q};
    in_tgt = (x_e >= {1'b0, tx_q}) && (x_e < tx_end) &&
             (y_e >= {1'b0, ty_q}) && (y_e < ty_end);
    rgb_p0 = vld_p0 ? pixel_colour(in_tgt, mode_q, DATA_W'(x_p0)) : '0;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      {o_R, o_G, o_B} <= '0;
      o_X_pos         <= '0;
      o_Y_pos         <= '0;
      o_valid         <= 1'b0;
      o_new_frame     <= 1'b0;
      o_end_frame     <= 1'b0;
      o_frame_cnt     <= '0;
    end else begin
      {o_R, o_G, o_B} <= rgb_p0;
      o_X_pos         <= x_p0;
      o_Y_pos         <= y_p0;
      o_valid         <= vld_p0;
      o_new_frame     <= nf_p0;
      o_end_frame     <= ef_p0;
      o_frame_cnt     <= frame_cnt_p0;
    end
  end

endmodule

// File: tb/tb_ccd_pattern_gen.sv
// Self-checking bench for ccd_pattern_gen on a small 8x4 frame: every output
// cycle is compared with expectations computed from the frame geometry.
module tb_ccd_pattern_gen;

  localparam int HA = 8, VA = 4, HB = 2, VB = 3;
  localparam int LINE   = HA + HB;
  localparam int PERIOD = 1 + VA * HA + (VA - 1) * HB + VB;
  localparam int ACT_END = VA * LINE - HB;

  typedef struct packed {
    logic        mode;
    logic [12:0] tx;
    logic [12:0] ty;
    logic [12:0] sz;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_mode;
  logic [12:0] i_tgt_x, i_tgt_y, i_tgt_size;
  logic [9:0]  o_R, o_G, o_B;
  logic [12:0] o_X_pos, o_Y_pos;
  logic        o_valid, o_new_frame, o_end_frame;
  logic [15:0] o_frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;

  always #5 clk = ~clk;

  ccd_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
    .DATA_W(10), .POS_W(13)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode),
    .i_tgt_x(i_tgt_x), .i_tgt_y(i_tgt_y), .i_tgt_size(i_tgt_size),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_X_pos(o_X_pos), .o_Y_pos(o_Y_pos),
    .o_valid(o_valid), .o_new_frame(o_new_frame), .o_end_frame(o_end_frame),
    .o_frame_cnt(o_frame_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {5'b0, o_R, o_G, o_B, o_X_pos, o_Y_pos, o_valid, o_new_frame, o_end_frame};
  endfunction

  function automatic logic [63:0] exp_vec(input int r, input int g, input int b,
                                          input int x, input int y,
                                          input bit v, input bit nf, input bit ef);
    return {5'b0, 10'(r), 10'(g), 10'(b), 13'(x), 13'(y), v, nf, ef};
  endfunction

  task automatic apply(input cfg_t c);
    i_mode     = c.mode;
    i_tgt_x    = c.tx;
    i_tgt_y    = c.ty;
    i_tgt_size = c.sz;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.mode = 1'($urandom_range(0, 1));
    c.tx   = 13'($urandom_range(0, 9));
    c.ty   = 13'($urandom_range(0, 5));
    c.sz   = 13'($urandom_range(0, 5));
    return c;
  endfunction

  task automatic check_idle(input string tag);
    check(tag, obs_vec(), 64'd0);
    check({tag, " cnt"}, {48'd0, o_frame_cnt}, 64'(frames_done & 16'hFFFF));
  endtask

  task automatic wait_nf(input string tag);
    for (int i = 0; i < 6 && !o_new_frame; i++) step();
    check(tag, {63'd0, o_new_frame}, 64'd1);
  endtask

  // Checks one frame starting on its o_new_frame cycle. The next frame's config
  // is driven at chg_at (and again at the frame's last cycle).
  task automatic frame_check(input string name, input cfg_t nxt, input int chg_at,
                             input int drop_at, input int rst_at);
    int tx, ty, sz, ex, ey, tp, er, eg, eb;
    bit mode, ev, enf, eef, tgt;
    mode = i_mode; tx = int'(i_tgt_x); ty = int'(i_tgt_y); sz = int'(i_tgt_size);
    for (int t = 0; t < PERIOD; t++) begin
      ex = 0; ey = 0; ev = 0; enf = (t == 0); eef = 0; er = 0; eg = 0; eb = 0;
      if (t > 0) begin
        tp = t - 1;
        if (tp < ACT_END) begin
          ey = tp / LINE;
          if (tp % LINE < HA) begin ev = 1; ex = tp % LINE; end
          else ex = HA - 1;
        end else begin
          ex = HA - 1; ey = VA - 1; eef = (tp == ACT_END);
        end
      end
      if (eef) frames_done++;
      if (ev) begin
        tgt = (ex >= tx) && (ex < tx + sz) && (ey >= ty) && (ey < ty + sz);
        if (tgt) begin er = 1023; eg = 0; eb = 0; end
        else begin er = 256; eb = 256; eg = mode ? (ex & 1023) : 256; end
      end
      check($sformatf("%s t=%0d", name, t), obs_vec(), exp_vec(er, eg, eb, ex, ey, ev, enf, eef));
      check($sformatf("%s cnt t=%0d", name, t), {48'd0, o_frame_cnt}, 64'(frames_done & 16'hFFFF));
      if (t == rst_at) begin
        rst = 1'b0;
        step();
        frames_done = 0;
        check_idle({name, " after rst"});
        return;
      end
      if (t == drop_at) i_enable = 1'b0;
      if (t == chg_at || t == PERIOD - 1) apply(nxt);
      step();
    end
  endtask

  initial begin
    cfg_t c;
    rst = 1'b0; i_enable = 1'b0;
    c = '0; apply(c);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("reset %0d", i));
    end

    c = '{mode: 1'b0, tx: 13'd3, ty: 13'd1, sz: 13'd2}; apply(c);
    i_enable = 1'b1; rst = 1'b1;
    wait_nf("first new_frame");

    frame_check("tgt31", '{mode: 1'b1, tx: 13'd7, ty: 13'd3, sz: 13'd4}, -1, -1, -1);
    frame_check("clip73", '{mode: 1'b0, tx: 13'd2, ty: 13'd2, sz: 13'd0}, -1, -1, -1);
    frame_check("none_m0", '{mode: 1'b1, tx: 13'd2, ty: 13'd2, sz: 13'd0}, -1, -1, -1);
    frame_check("none_m1", '{mode: 1'b1, tx: 13'd3, ty: 13'd0, sz: 13'd8190}, -1, -1, -1);
    frame_check("big_size", rand_cfg(), 10, -1, -1);
    for (int i = 0; i < 6; i++)
      frame_check($sformatf("rand%0d", i), rand_cfg(), $urandom_range(1, PERIOD - 1), -1, -1);

    c = rand_cfg();
    frame_check("drop", c, -1, 1 + 2 * LINE + 5, -1);
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("idle %0d", i));
      step();
    end

    i_enable = 1'b1;
    wait_nf("restart new_frame");
    frame_check("rst_mid", rand_cfg(), -1, -1, 1 + LINE + 2);
    rst = 1'b1;
    wait_nf("post-rst new_frame");
    frame_check("fresh", rand_cfg(), -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
